fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the pipelined CPU.
- Generalises the two-operand, two-stage forwarding selector to N source operands and N producer stages, with configurable register-address width.
- Adds load-use stall detection with a multi-cycle stall FSM and a saturating stall-cycle counter.
- Sits between the decode stage and the execute-stage operand muxes; also drives the fetch and decode hold signals and the execute flush.

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction in decode
NUM_STAGES, 3, producer stages checked; stage 1 = EX (youngest) to stage NUM_STAGES (oldest)
SEL_W, 2, forward-select width per operand; must satisfy 2^SEL_W > NUM_STAGES
LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard; minimum 1
CNT_W, 16, stall counter width

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous reset, active-high
wb_addr_stages  in  NUM_STAGES*REG_ADDR_W  destination address per stage; slice k-1 holds stage k
reg_write_stages  in  NUM_STAGES  RegWrite per stage; bit k-1 is stage k
mem_readE  in  1  stage-1 (EX) instruction is a load
src_addrD  in  NUM_SRC*REG_ADDR_W  decode-stage source addresses, one slice per operand
src_validD  in  NUM_SRC  operand j is actually read
Forward  out  NUM_SRC*SEL_W  registered select per operand: 0 = register file, k = stage k
StallF  out  1  hold PC
StallD  out  1  hold the IF/ID register
FlushE  out  1  insert a bubble into ID/EX
stall_count  out  CNT_W  total stall cycles, saturating

Behaviour:
Reset:
- RESET high asynchronously forces Forward=0, FSM=RUN, hold counter=0, stall_count=0.
- While RESET is high, StallF, StallD and FlushE are 0.

Match rule:
- Operand j matches stage k when src_validD[j] && reg_write_stages[k-1] && wb_addr(k)==src_addr(j) && wb_addr(k)!=0.
- Register 0 never forwards and never stalls.

Forwarding:
- Computed from decode-stage inputs and registered on the CLOCK rising edge, so the select is valid during the following (EX) cycle. Latency is 1.
- Priority goes to the youngest stage: lowest k wins.
- With no match, the select is 0.
- On an edge where FlushE is 1, every Forward slice loads 0 (the bubble carries no forward).

Load-use detect:
- hazard = mem_readE && (any j matching stage 1).
- hazard is combinational; it is evaluated only in state RUN.

FSM:
- RUN:
  - StallF = StallD = FlushE = hazard.
  - If hazard and LOAD_USE_CYCLES>1: go to HOLD and load hold counter = LOAD_USE_CYCLES-2.
  - If hazard and LOAD_USE_CYCLES==1: stay in RUN.
- HOLD:
  - StallF = StallD = FlushE = 1 unconditionally; detection is ignored.
  - If counter==0: go to RUN.
  - Otherwise: decrement the counter.
- Each hazard yields exactly LOAD_USE_CYCLES consecutive stall cycles.
- After a stall, the bubble sits in EX, so the same pair cannot re-trigger.
- A new load/consumer pair is detected on the first RUN cycle after a HOLD.

stall_count:
- Increments on each rising edge where StallD==1.
- Holds at all-ones (no wrap).

Simultaneous events:
- A hazard plus a stage-2 match on the other operand: stall takes precedence.
- The Forward registers load 0 that edge. Selects are recomputed on the edge after the stall ends.

Reset mid-stall:
- The FSM returns to RUN immediately and stall outputs drop asynchronously.
- stall_count clears.

Illegal parameters:
- LOAD_USE_CYCLES<1, or NUM_STAGES ≥ 2^SEL_W, is a fatal elaboration error.

Test Plan:
- Priority with defaults: stage1 addr=5 and stage2 addr=5, both RegWrite, src0=5, mem_readE=0 -> after next edge Forward[0]=1, Forward[1]=0, no stall.
- Zero register: stage1 addr=0 with RegWrite, src0=0 -> Forward[0]=0, no stall, even with mem_readE=1.
- Load-use with LOAD_USE_CYCLES=1: mem_readE=1, stage1 addr=7, src1=7 valid -> StallF/StallD/FlushE=1 for exactly 1 cycle, Forward=0 on that edge, stall_count=1.
- Multi-cycle stall with LOAD_USE_CYCLES=3: same hazard -> stall outputs high for exactly 3 cycles, FSM RUN→HOLD→HOLD→RUN, stall_count=3.
- Operand not read: src_validD[1]=0 with a matching load in EX -> no stall; then set it to 1 -> stall.
- Reset and saturation: assert RESET in the 2nd HOLD cycle -> stall outputs 0 and stall_count=0 within the same cycle. Separately, with CNT_W=4 and 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for N decode operands against N producer stages.
// Forward selects are registered for the EX cycle; stall/flush outputs are combinational from the FSM.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int NUM_SRC         = 2,
  parameter int NUM_STAGES      = 3,
  parameter int SEL_W           = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                             CLOCK,
  input  logic                             RESET,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] wb_addr_stages,
  input  logic [NUM_STAGES-1:0]            reg_write_stages,
  input  logic                             mem_readE,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addrD,
  input  logic [NUM_SRC-1:0]               src_validD,
  output logic [NUM_SRC*SEL_W-1:0]         Forward,
  output logic                             StallF,
  output logic                             StallD,
  output logic                             FlushE,
  output logic [CNT_W-1:0]                 stall_count
);

  localparam int HC_W = (LOAD_USE_CYCLES > 2) ? $clog2(LOAD_USE_CYCLES - 1) : 1;

  if (LOAD_USE_CYCLES < 1 || NUM_STAGES >= (1 << SEL_W)) begin : g_param_check
    $fatal(1, "fwd_hazard_unit: LOAD_USE_CYCLES must be >= 1 and NUM_STAGES < 2**SEL_W");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [HC_W-1:0]                 r_hold_cnt;
  logic [HC_W-1:0]                 w_hold_next;
  logic [NUM_SRC*SEL_W-1:0]        r_forward;
  logic [NUM_SRC*SEL_W-1:0]        w_fwd_next;
  logic [CNT_W-1:0]                r_stall_count;
  logic [NUM_SRC-1:0][NUM_STAGES-1:0] w_match;
  logic                            w_hazard;
  logic                            w_stall;

  // Operand/stage match matrix; register 0 is never a producer.
  always_comb begin
    w_match = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        w_match[j][k] = src_validD[j] && reg_write_stages[k] &&
                        (wb_addr_stages[k*REG_ADDR_W +: REG_ADDR_W] == src_addrD[j*REG_ADDR_W +: REG_ADDR_W]) &&
                        (wb_addr_stages[k*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}});
      end
    end
  end

  // Youngest-stage-wins select per operand (scan oldest to youngest) and load-use detect.
  always_comb begin
    w_fwd_next = {(NUM_SRC*SEL_W){1'b0}};
    w_hazard   = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        w_fwd_next[j*SEL_W +: SEL_W] = w_match[j][k] ? SEL_W'(k + 1) : w_fwd_next[j*SEL_W +: SEL_W];
      end
      w_hazard = w_hazard | (mem_readE & w_match[j][0]);
    end
  end

  // Stall FSM next state; HOLD ignores detection until its countdown expires.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        w_stall = w_hazard;
        if (w_hazard && (LOAD_USE_CYCLES > 1)) begin
          w_state_next = HOLD;
          w_hold_next  = HC_W'(LOAD_USE_CYCLES - 2);
        end else begin
          w_state_next = RUN;
        end
      end
      HOLD: begin
        w_stall = 1'b1;
        if (r_hold_cnt == {HC_W{1'b0}}) begin
          w_state_next = RUN;
        end else begin
          w_hold_next = r_hold_cnt - HC_W'(1);
        end
      end
      default: begin
        w_state_next = RUN;
        w_hold_next  = {HC_W{1'b0}};
      end
    endcase
  end

  // State, hold counter, forward selects and saturating stall counter.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state       <= RUN;
      r_hold_cnt    <= {HC_W{1'b0}};
      r_forward     <= {(NUM_SRC*SEL_W){1'b0}};
      r_stall_count <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_forward  <= w_stall ? {(NUM_SRC*SEL_W){1'b0}} : w_fwd_next;
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end else begin
        r_stall_count <= r_stall_count;
      end
    end
  end

  // Stall outputs are forced low while reset is held, even if a hazard is present.
  assign StallF      = w_stall & ~RESET;
  assign StallD      = w_stall & ~RESET;
  assign FlushE      = w_stall & ~RESET;
  assign Forward     = r_forward;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (default, 3-cycle load-use, 4-bit counter)
// share decode/stage inputs and each has its own mem_readE.
module tb_fwd_hazard_unit;

  logic        CLOCK;
  logic        RESET;
  logic [14:0] wb_addr_stages;
  logic [2:0]  reg_write_stages;
  logic [9:0]  src_addrD;
  logic [1:0]  src_validD;
  logic        mem_readE, mem_readE3, mem_readE4;

  logic [3:0]  fwd0, fwd3, fwd4;
  logic        sf0, sd0, fe0, sf3, sd3, fe3, sf4, sd4, fe4;
  logic [15:0] cnt0, cnt3;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  fwd_hazard_unit u0 (
    .CLOCK(CLOCK), .RESET(RESET), .wb_addr_stages(wb_addr_stages), .reg_write_stages(reg_write_stages),
    .mem_readE(mem_readE), .src_addrD(src_addrD), .src_validD(src_validD), .Forward(fwd0),
    .StallF(sf0), .StallD(sd0), .FlushE(fe0), .stall_count(cnt0));

  fwd_hazard_unit #(.LOAD_USE_CYCLES(3)) u3 (
    .CLOCK(CLOCK), .RESET(RESET), .wb_addr_stages(wb_addr_stages), .reg_write_stages(reg_write_stages),
    .mem_readE(mem_readE3), .src_addrD(src_addrD), .src_validD(src_validD), .Forward(fwd3),
    .StallF(sf3), .StallD(sd3), .FlushE(fe3), .stall_count(cnt3));

  fwd_hazard_unit #(.CNT_W(4)) u4 (
    .CLOCK(CLOCK), .RESET(RESET), .wb_addr_stages(wb_addr_stages), .reg_write_stages(reg_write_stages),
    .mem_readE(mem_readE4), .src_addrD(src_addrD), .src_validD(src_validD), .Forward(fwd4),
    .StallF(sf4), .StallD(sd4), .FlushE(fe4), .stall_count(cnt4));

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clear_in();
    wb_addr_stages   = 15'd0;
    reg_write_stages = 3'd0;
    src_addrD        = 10'd0;
    src_validD       = 2'd0;
  endtask

  task automatic set_stage(input int k, input logic [4:0] a, input logic we);
    wb_addr_stages[(k-1)*5 +: 5] = a;
    reg_write_stages[k-1]        = we;
  endtask

  task automatic set_src(input int j, input logic [4:0] a, input logic v);
    src_addrD[j*5 +: 5] = a;
    src_validD[j]       = v;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    mem_readE = 1'b0; mem_readE3 = 1'b0; mem_readE4 = 1'b0;
    clear_in();
    // Hazard present while reset is held: stalls must stay low.
    set_stage(1, 5'd7, 1'b1); set_src(1, 5'd7, 1'b1);
    mem_readE = 1'b1; mem_readE3 = 1'b1; mem_readE4 = 1'b1;
    #12;
    expect_v("rst_stallD", 32'd0);  check_v({31'd0, sd0});
    expect_v("rst_flushE3", 32'd0); check_v({31'd0, fe3});
    expect_v("rst_fwd", 32'd0);     check_v({28'd0, fwd0});
    expect_v("rst_cnt", 32'd0);     check_v({16'd0, cnt0});
    mem_readE = 1'b0; mem_readE3 = 1'b0; mem_readE4 = 1'b0;
    clear_in();
    @(negedge CLOCK);
    RESET = 1'b0;

    // Youngest stage wins: stage1 and stage2 both write r5.
    set_stage(1, 5'd5, 1'b1); set_stage(2, 5'd5, 1'b1); set_src(0, 5'd5, 1'b1);
    #1;
    expect_v("prio_nostall", 32'd0); check_v({31'd0, sd0});
    expect_v("prio_fwd0", 32'd1);
    expect_v("prio_fwd1", 32'd0);
    tick();
    check_v({30'd0, fwd0[1:0]});
    check_v({30'd0, fwd0[3:2]});

    // Stage2 beats stage3 on operand 1.
    clear_in(); set_stage(2, 5'd6, 1'b1); set_stage(3, 5'd6, 1'b1); set_src(1, 5'd6, 1'b1);
    expect_v("s2_over_s3", 32'h8);
    tick();
    check_v({28'd0, fwd0});

    // Stage3 only, since stage2 has RegWrite low.
    clear_in(); set_stage(2, 5'd3, 1'b0); set_stage(3, 5'd3, 1'b1); set_src(0, 5'd3, 1'b1);
    expect_v("s3_only", 32'h3);
    tick();
    check_v({28'd0, fwd0});

    // Register 0 never forwards or stalls.
    clear_in(); set_stage(1, 5'd0, 1'b1); set_src(0, 5'd0, 1'b1); mem_readE = 1'b1;
    #1;
    expect_v("zero_nostall", 32'd0); check_v({31'd0, sd0});
    expect_v("zero_fwd", 32'd0);
    tick();
    check_v({28'd0, fwd0});
    mem_readE = 1'b0;

    // Load-use with a simultaneous stage2 match on operand 0.
    clear_in(); set_stage(2, 5'd5, 1'b1); set_src(0, 5'd5, 1'b1);
    expect_v("pre_fwd", 32'h2);
    tick();
    check_v({28'd0, fwd0});
    set_stage(1, 5'd7, 1'b1); set_src(1, 5'd7, 1'b1); mem_readE = 1'b1;
    #1;
    expect_v("lu_stallF", 32'd1); check_v({31'd0, sf0});
    expect_v("lu_stallD", 32'd1); check_v({31'd0, sd0});
    expect_v("lu_flushE", 32'd1); check_v({31'd0, fe0});
    expect_v("lu_fwd_zero", 32'd0);
    expect_v("lu_cnt", 32'd1);
    tick();
    check_v({28'd0, fwd0});
    check_v({16'd0, cnt0});
    mem_readE = 1'b0;
    #1;
    expect_v("lu_released", 32'd0); check_v({31'd0, sd0});
    expect_v("lu_recompute", 32'h6);
    expect_v("lu_cnt_hold", 32'd1);
    tick();
    check_v({28'd0, fwd0});
    check_v({16'd0, cnt0});

    // Operand not read: no stall until its valid rises.
    clear_in(); set_stage(1, 5'd9, 1'b1); set_src(1, 5'd9, 1'b0); mem_readE = 1'b1;
    #1;
    expect_v("invalid_nostall", 32'd0); check_v({31'd0, sd0});
    set_src(1, 5'd9, 1'b1);
    #1;
    expect_v("valid_stall", 32'd1); check_v({31'd0, sd0});
    expect_v("valid_cnt", 32'd2);
    tick();
    check_v({16'd0, cnt0});
    mem_readE = 1'b0;

    // Three-cycle load-use on u3.
    clear_in(); set_stage(1, 5'd7, 1'b1); set_src(1, 5'd7, 1'b1); mem_readE3 = 1'b1;
    #1;
    expect_v("m3_c1", 32'd1); check_v({31'd0, sd3});
    tick();
    expect_v("m3_c2", 32'd1);   check_v({31'd0, sd3});
    expect_v("m3_cnt1", 32'd1); check_v({16'd0, cnt3});
    tick();
    expect_v("m3_c3", 32'd1);   check_v({31'd0, fe3});
    expect_v("m3_cnt2", 32'd2); check_v({16'd0, cnt3});
    tick();
    mem_readE3 = 1'b0;
    #1;
    expect_v("m3_done", 32'd0);  check_v({31'd0, sd3});
    expect_v("m3_cnt3", 32'd3);  check_v({16'd0, cnt3});
    expect_v("m3_fwd0", 32'd0);  check_v({28'd0, fwd3});
    expect_v("m3_recompute", 32'h4);
    expect_v("m3_u0_idle", 32'd2);
    tick();
    check_v({28'd0, fwd3});
    check_v({16'd0, cnt0});

    // Reset asserted during the second HOLD cycle.
    mem_readE3 = 1'b1;
    tick();
    tick();
    expect_v("ms_hold2", 32'd1); check_v({31'd0, sd3});
    #1;
    RESET = 1'b1;
    #1;
    expect_v("ms_stallF", 32'd0); check_v({31'd0, sf3});
    expect_v("ms_stallD", 32'd0); check_v({31'd0, sd3});
    expect_v("ms_flushE", 32'd0); check_v({31'd0, fe3});
    expect_v("ms_cnt3", 32'd0);   check_v({16'd0, cnt3});
    expect_v("ms_cnt0", 32'd0);   check_v({16'd0, cnt0});
    mem_readE3 = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b0;

    // Continuous hazard on u4 saturates its 4-bit counter.
    mem_readE4 = 1'b1;
    repeat (14) tick();
    expect_v("sat_14", 32'd14); check_v({28'd0, cnt4});
    repeat (6) tick();
    expect_v("sat_15", 32'd15);   check_v({28'd0, cnt4});
    expect_v("sat_stall", 32'd1); check_v({31'd0, sd4});
    mem_readE4 = 1'b0;

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
